// File: rtl/clk_enable_gen.sv
// -----------------------------------------------------------------------------
// clk_enable_gen
//
// Lock-qualified reset sequencer and multi-channel fractional clock-enable
// generator. It runs in the PLL output clock domain. It waits for PLL LOCK to
// be stable for LOCK_CYCLES synchronized cycles and then releases the
// downstream reset. After that, each channel emits single-cycle enable pulses
// at f_clk * inc / 2^ACC_WIDTH, using one phase accumulator per channel.
//
// Ports:
//   clkin      in   1             PLL output clock, the only clock
//   rst_n      in   1             synchronous active-low reset
//   pll_locked in   1             PLL LOCK, asynchronous to clkin
//   pause      in   1             freeze accumulators, suppress enables
//   cfg_we     in   1             increment write strobe
//   cfg_sel    in   SEL_W         target channel of the write
//   cfg_inc    in   ACC_WIDTH     new increment
//   ready      out  1             lock qualified, generator running
//   rst_out_n  out  1             synchronous active-low downstream reset
//   ce         out  CHANNELS      per-channel one-cycle enable pulses
//   lock_lost  out  1             sticky: lock dropped after ready was reached
// -----------------------------------------------------------------------------
module clk_enable_gen #(
    parameter int CHANNELS    = 2,
    parameter int ACC_WIDTH   = 16,
    parameter logic [CHANNELS*ACC_WIDTH-1:0] INC_INIT = {16'd17596, 16'd5865},
    parameter int LOCK_CYCLES = 1024,
    parameter int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                  clkin,
    input  logic                  rst_n,
    input  logic                  pll_locked,
    input  logic                  pause,
    input  logic                  cfg_we,
    input  logic [SEL_W-1:0]      cfg_sel,
    input  logic [ACC_WIDTH-1:0]  cfg_inc,
    output logic                  ready,
    output logic                  rst_out_n,
    output logic [CHANNELS-1:0]   ce,
    output logic                  lock_lost
);

    typedef enum logic {
        ST_WAIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam int                CNT_W    = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [SEL_W:0]    SEL_LIM  = (SEL_W + 1)'(CHANNELS);

    logic                  lock_meta_r;
    logic                  lock_sync_r;
    state_t                state_r;
    logic [CNT_W-1:0]      lock_cnt_r;
    logic                  ready_r;
    logic                  rst_out_n_r;
    logic                  lock_lost_r;
    logic [CHANNELS-1:0]   ce_r;
    logic [ACC_WIDTH-1:0]  acc_r [CHANNELS];
    logic [ACC_WIDTH-1:0]  inc_r [CHANNELS];
    logic [ACC_WIDTH:0]    sum_s [CHANNELS];
    logic                  run_s;
    logic                  sel_ok_s;

    // Two-flop synchronizer for the asynchronous PLL lock.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            lock_meta_r <= 1'b0;
            lock_sync_r <= 1'b0;
        end else begin
            lock_meta_r <= pll_locked;
            lock_sync_r <= lock_meta_r;
        end
    end

    // Lock qualifier: count consecutive synchronized-lock cycles, then run.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            state_r     <= ST_WAIT;
            lock_cnt_r  <= {CNT_W{1'b0}};
            ready_r     <= 1'b0;
            lock_lost_r <= 1'b0;
            rst_out_n_r <= 1'b0;
        end else begin
            rst_out_n_r <= ready_r;
            case (state_r)
                ST_WAIT: begin
                    if (!lock_sync_r) begin
                        // Any drop restarts qualification from zero.
                        lock_cnt_r <= {CNT_W{1'b0}};
                    end else if (lock_cnt_r == CNT_LAST) begin
                        state_r    <= ST_RUN;
                        ready_r    <= 1'b1;
                        lock_cnt_r <= {CNT_W{1'b0}};
                    end else begin
                        lock_cnt_r <= lock_cnt_r + CNT_W'(1);
                    end
                end
                ST_RUN: begin
                    if (!lock_sync_r) begin
                        state_r     <= ST_WAIT;
                        ready_r     <= 1'b0;
                        lock_lost_r <= 1'b1;
                    end else begin
                        ready_r     <= 1'b1;
                    end
                end
                default: begin
                    state_r    <= ST_WAIT;
                    ready_r    <= 1'b0;
                    lock_cnt_r <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    // Accumulate qualifier and per-channel add with carry-out.
    // ready_r alone lags the lock drop by one edge. The synchronized lock is
    // therefore also required, so enables are already forced low on the edge
    // where ready falls.
    always_comb begin
        run_s    = ready_r & lock_sync_r;
        sel_ok_s = ({1'b0, cfg_sel} < SEL_LIM);
        for (int i = 0; i < CHANNELS; i++) begin
            sum_s[i] = {1'b0, acc_r[i]} + {1'b0, inc_r[i]};
        end
    end

    // Phase accumulators and registered enable pulses.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            ce_r <= {CHANNELS{1'b0}};
            for (int i = 0; i < CHANNELS; i++) begin
                acc_r[i] <= {ACC_WIDTH{1'b0}};
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (!run_s) begin
                    acc_r[i] <= {ACC_WIDTH{1'b0}};
                    ce_r[i]  <= 1'b0;
                end else if (pause) begin
                    // Phase is held so the long-run rate stays exact.
                    ce_r[i]  <= 1'b0;
                end else begin
                    acc_r[i] <= sum_s[i][ACC_WIDTH-1:0];
                    ce_r[i]  <= sum_s[i][ACC_WIDTH];
                end
            end
        end
    end

    // Increment registers. Writes are accepted in any state, and the phase
    // is not touched. A carry computed on the write edge still used the old
    // increment.
    always_ff @(posedge clkin) begin
        if (!rst_n) begin
            for (int i = 0; i < CHANNELS; i++) begin
                inc_r[i] <= INC_INIT[i*ACC_WIDTH +: ACC_WIDTH];
            end
        end else if (cfg_we && sel_ok_s) begin
            inc_r[cfg_sel] <= cfg_inc;
        end
    end

    assign ready     = ready_r;
    assign rst_out_n = rst_out_n_r;
    assign ce        = ce_r;
    assign lock_lost = lock_lost_r;

endmodule

// File: tb/tb_clk_enable_gen.sv
// -----------------------------------------------------------------------------
// tb_clk_enable_gen
//
// Self-checking bench for clk_enable_gen. The configuration is 3 channels,
// 16-bit accumulators and LOCK_CYCLES=4. A behavioural model tracks:
//   - the lock qualifier as a run length of synchronized lock samples;
//   - each channel's phase as an unbounded cumulative sum, where a pulse is
//     due whenever the sum crosses a multiple of 2^16.
// A compare process checks every output on each falling edge. Directed
// sequences add literal expectations for timing and pulse counts.
// -----------------------------------------------------------------------------
module tb_clk_enable_gen;

    localparam int CH = 3;
    localparam int W  = 16;
    localparam int LC = 4;
    localparam logic [CH*W-1:0] INC_INIT = {16'd1000, 16'd17596, 16'd5865};

    logic          clk = 1'b0;
    logic          rst_n;
    logic          pll_locked;
    logic          pause;
    logic          cfg_we;
    logic [1:0]    cfg_sel;
    logic [W-1:0]  cfg_inc;
    logic          ready;
    logic          rst_out_n;
    logic [CH-1:0] ce;
    logic          lock_lost;

    int checks = 0;
    int errors = 0;

    clk_enable_gen #(
        .CHANNELS(CH), .ACC_WIDTH(W), .INC_INIT(INC_INIT), .LOCK_CYCLES(LC)
    ) dut (
        .clkin(clk), .rst_n(rst_n), .pll_locked(pll_locked), .pause(pause),
        .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_inc(cfg_inc),
        .ready(ready), .rst_out_n(rst_out_n), .ce(ce), .lock_lost(lock_lost)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic          m_valid = 1'b0;
    logic          m_d1, m_d2;          // pll_locked delayed by one / two edges
    int            m_streak;            // consecutive edges with lock seen
    logic          m_ready, m_rout, m_lost;
    logic [CH-1:0] m_ce;
    longint        m_sum [CH];          // cumulative phase since run start
    logic [W-1:0]  m_inc [CH];

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid  <= 1'b1;
            m_d1     <= 1'b0;
            m_d2     <= 1'b0;
            m_streak <= 0;
            m_ready  <= 1'b0;
            m_rout   <= 1'b0;
            m_lost   <= 1'b0;
            m_ce     <= '0;
            for (int i = 0; i < CH; i++) begin
                m_sum[i] <= 0;
                m_inc[i] <= INC_INIT[i*W +: W];
            end
        end else begin
            m_d1     <= pll_locked;
            m_d2     <= m_d1;
            m_streak <= m_d2 ? m_streak + 1 : 0;
            m_ready  <= m_d2 && (m_ready || (m_streak + 1 >= LC));
            m_lost   <= m_lost || (m_ready && !m_d2);
            m_rout   <= m_ready;
            for (int i = 0; i < CH; i++) begin
                if (!(m_ready && m_d2)) begin
                    m_sum[i] <= 0;
                    m_ce[i]  <= 1'b0;
                end else if (pause) begin
                    m_ce[i]  <= 1'b0;
                end else begin
                    m_sum[i] <= m_sum[i] + longint'(m_inc[i]);
                    m_ce[i]  <= ((m_sum[i] + longint'(m_inc[i])) / 65536) != (m_sum[i] / 65536);
                end
            end
            if (cfg_we && cfg_sel < 2'(CH)) m_inc[cfg_sel] <= cfg_inc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle compare against the model.
    always @(negedge clk) begin
        if (m_valid) begin
            check("model_ready", 32'(ready), 32'(m_ready));
            check("model_rst_out_n", 32'(rst_out_n), 32'(m_rout));
            check("model_lock_lost", 32'(lock_lost), 32'(m_lost));
            check("model_ce", 32'(ce), 32'(m_ce));
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [1:0] sel, input logic [W-1:0] val);
        cfg_we = 1'b1; cfg_sel = sel; cfg_inc = val;
        tick(1);
        cfg_we = 1'b0;
    endtask

    int cnt [CH];
    int adj;
    int paused_pulses;
    logic [CH-1:0] prev;

    initial begin
        rst_n = 1'b0; pll_locked = 1'b0; pause = 1'b0;
        cfg_we = 1'b0; cfg_sel = 2'd0; cfg_inc = '0;
        tick(3);
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_rst_out_n", 32'(rst_out_n), 32'd0);
        check("rst_ce", 32'(ce), 32'd0);
        check("rst_lock_lost", 32'(lock_lost), 32'd0);

        // Lock rises and holds; first sampling edge is k.
        rst_n = 1'b1;
        tick(2);
        pll_locked = 1'b1;
        tick(5);                        // after edge k+4
        check("rise_ready_early", 32'(ready), 32'd0);
        check("rise_ce_early", 32'(ce), 32'd0);
        tick(1);                        // after edge k+5
        check("rise_ready", 32'(ready), 32'd1);
        check("rise_rst_out_n_lag", 32'(rst_out_n), 32'd0);
        check("rise_ce_at_ready", 32'(ce), 32'd0);
        tick(1);                        // after edge k+6
        check("rise_rst_out_n", 32'(rst_out_n), 32'd1);

        // 65536 running edges plus 100 paused edges, all from phase 0.
        for (int c = 0; c < CH; c++) cnt[c] = (c == 0) ? 32'(ce[0]) : 32'(ce[c]);
        adj = 0; paused_pulses = 0; prev = ce;
        for (int i = 1; i < 65636; i++) begin
            pause = (i >= 1000 && i < 1100);
            tick(1);
            for (int c = 0; c < CH; c++) begin
                cnt[c] += 32'(ce[c]);
                if (ce[c] && prev[c]) adj++;
            end
            if (pause) paused_pulses += $countones(ce);
            prev = ce;
        end
        pause = 1'b0;
        check("count_ch0_5865", 32'(cnt[0]), 32'd5865);
        check("count_ch1_17596", 32'(cnt[1]), 32'd17596);
        check("count_ch2_1000", 32'(cnt[2]), 32'd1000);
        check("no_adjacent_pulses", 32'(adj), 32'd0);
        check("no_pulse_in_pause", 32'(paused_pulses), 32'd0);

        // Reprogram rates; the sel=3 write must be ignored.
        cfg_write(2'd0, 16'd32768);
        cfg_write(2'd1, 16'd16384);
        cfg_write(2'd2, 16'd0);
        cfg_write(2'd3, 16'd1);
        for (int c = 0; c < CH; c++) cnt[c] = 0;
        for (int i = 0; i < 100; i++) begin
            tick(1);
            for (int c = 0; c < CH; c++) cnt[c] += 32'(ce[c]);
        end
        check("half_rate_ch0", 32'(cnt[0]), 32'd50);
        check("quarter_rate_ch1", 32'(cnt[1]), 32'd25);
        check("zero_rate_ch2", 32'(cnt[2]), 32'd0);

        // Lock drops while running; sampled first at edge k.
        pll_locked = 1'b0;
        tick(2);                        // after edge k+1
        check("loss_ready_hold", 32'(ready), 32'd1);
        tick(1);                        // after edge k+2
        check("loss_ready", 32'(ready), 32'd0);
        check("loss_ce", 32'(ce), 32'd0);
        check("loss_lock_lost", 32'(lock_lost), 32'd1);
        check("loss_rst_out_n_lag", 32'(rst_out_n), 32'd1);
        tick(1);
        check("loss_rst_out_n", 32'(rst_out_n), 32'd0);
        pll_locked = 1'b1;
        tick(10);
        check("relock_ready", 32'(ready), 32'd1);
        check("relock_lock_lost_sticky", 32'(lock_lost), 32'd1);

        // Mid-run reset with lock still present.
        rst_n = 1'b0;
        tick(1);
        check("midrst_ready", 32'(ready), 32'd0);
        check("midrst_lock_lost", 32'(lock_lost), 32'd0);
        check("midrst_rst_out_n", 32'(rst_out_n), 32'd0);
        pll_locked = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(3);

        // Glitch: lock high 3 edges, low 1, then high (k = first high edge).
        pll_locked = 1'b1;
        tick(3);
        pll_locked = 1'b0;
        cfg_write(2'd2, 16'd8192);      // write accepted while waiting
        pll_locked = 1'b1;
        tick(5);                        // after edge k+8
        check("glitch_ready_early", 32'(ready), 32'd0);
        tick(1);                        // after edge k+9
        check("glitch_ready", 32'(ready), 32'd1);
        check("glitch_lock_lost", 32'(lock_lost), 32'd0);
        cnt[2] = 0;
        for (int i = 0; i < 64; i++) begin
            tick(1);
            cnt[2] += 32'(ce[2]);
        end
        check("wait_write_ch2", 32'(cnt[2]), 32'd8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
